// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, zero-skew sync/blank/strobe outputs,
// a 3-source sticky maskable interrupt (hblank, vblank, line-compare) and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 48,
  parameter int H_SYNC     = 104,
  parameter int H_BP       = 152,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b1,
  parameter int XW         = 11,
  parameter int YW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [2:0]    irq_en,
  input  logic [2:0]    irq_clr,
  input  logic [YW-1:0] line_cmp,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic [2:0]    irq_pending,
  output logic          interrupt,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic          x_wrap;
  logic          y_wrap;
  logic          frame_wrap;
  logic          blank_n;
  logic          hs_on;
  logic          vs_on;
  logic [2:0]    event_vec;

  // Next raster position; the registered video outputs are derived from it so they line up with x/y.
  always_comb begin
    x_n    = x;
    y_n    = y;
    x_wrap = (x == X_LAST);
    y_wrap = (y == Y_LAST);
    if (!enable) begin
      x_n = '0;
      y_n = '0;
    end else if (x_wrap) begin
      x_n = '0;
      y_n = y_wrap ? '0 : y + YW'(1);
    end else begin
      x_n = x + XW'(1);
    end
    frame_wrap = enable && x_wrap && y_wrap;
    blank_n    = (x_n >= X_ACT) || (y_n >= Y_ACT);
    hs_on      = (x_n >= HS_START) && (x_n <= HS_LAST);
    vs_on      = (y_n >= VS_START) && (y_n <= VS_LAST);
    // Events look at the position currently shown, so pending rises one cycle later.
    event_vec  = {(x == X_ACT) && (y == line_cmp),
                  (x == '0) && (y == Y_ACT),
                  (x == X_ACT)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      blank       <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      irq_pending <= '0;
      frame_cnt   <= '0;
    end else begin
      x <= x_n;
      y <= y_n;
      if (enable) begin
        hsync       <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
        vsync       <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
        blank       <= blank_n;
        de          <= ~blank_n;
        line_start  <= (x_n == '0);
        frame_start <= (x_n == '0) && (y_n == '0);
      end else begin
        hsync       <= ~H_SYNC_POL;
        vsync       <= ~V_SYNC_POL;
        blank       <= 1'b1;
        de          <= 1'b0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
      // A new event overrides a simultaneous clear of the same bit.
      irq_pending <= (irq_pending & ~irq_clr) | (event_vec & irq_en);
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign interrupt = |irq_pending;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 16x8 raster: table-driven checkpoints, hand-written
// corner sequences and randomized stimulus, all compared every cycle against a position-index model.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW       = 4;
  localparam int YW       = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [2:0]    irq_en = '0;
  logic [2:0]    irq_clr = '0;
  logic [YW-1:0] line_cmp = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          hsync, vsync, blank, de, line_start, frame_start, interrupt;
  logic [2:0]    irq_pending;
  logic [15:0]   frame_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: 0 = just reset, 1 = disabled, 2 = running; pos is the linear pixel index in the frame.
  int       m_mode = 0;
  int       m_pos  = 0;
  int       m_fc   = 0;
  logic [2:0] m_pend = '0;

  typedef struct {
    logic       rst;
    logic       enable;
    logic [2:0] irq_en;
    logic [2:0] irq_clr;
    logic [3:0] line_cmp;
    int         cycles;
    int         ex;
    int         ey;
    int         epend;
    int         efc;
  } vec_t;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .irq_en(irq_en), .irq_clr(irq_clr),
    .line_cmp(line_cmp), .x(x), .y(y), .hsync(hsync), .vsync(vsync), .blank(blank),
    .de(de), .line_start(line_start), .frame_start(frame_start),
    .irq_pending(irq_pending), .interrupt(interrupt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int mx, my;
    logic [2:0] ev;
    mx = m_pos % HT;
    my = m_pos / HT;
    ev[0] = (mx == H_ACTIVE);
    ev[1] = (mx == 0) && (my == V_ACTIVE);
    ev[2] = (mx == H_ACTIVE) && (my == int'(line_cmp));
    if (rst) begin
      m_mode = 0;
      m_pos  = 0;
      m_fc   = 0;
      m_pend = '0;
    end else begin
      m_pend = (m_pend & ~irq_clr) | (ev & irq_en);
      if (enable) begin
        if (m_pos == HT * VT - 1) m_fc = (m_fc + 1) % 65536;
        m_pos  = (m_pos + 1) % (HT * VT);
        m_mode = 2;
      end else begin
        m_pos  = 0;
        m_mode = 1;
      end
    end
  endtask

  task automatic checkOutput();
    int mx, my;
    int e_hs, e_vs, e_blank, e_ls, e_fs;
    mx = m_pos % HT;
    my = m_pos / HT;
    if (m_mode == 2) begin
      e_hs    = (mx >= H_ACTIVE + H_FP && mx < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
      e_vs    = (my >= V_ACTIVE + V_FP && my < V_ACTIVE + V_FP + V_SYNC) ? 1 : 0;
      e_blank = (mx >= H_ACTIVE || my >= V_ACTIVE) ? 1 : 0;
      e_ls    = (mx == 0) ? 1 : 0;
      e_fs    = (m_pos == 0) ? 1 : 0;
    end else begin
      e_hs    = 1;
      e_vs    = 0;
      e_blank = (m_mode == 1) ? 1 : 0;
      e_ls    = 0;
      e_fs    = 0;
    end
    check_val("x", int'(x), mx);
    check_val("y", int'(y), my);
    check_val("hsync", int'(hsync), e_hs);
    check_val("vsync", int'(vsync), e_vs);
    check_val("blank", int'(blank), e_blank);
    check_val("de", int'(de), 1 - e_blank);
    check_val("line_start", int'(line_start), e_ls);
    check_val("frame_start", int'(frame_start), e_fs);
    check_val("irq_pending", int'(irq_pending), int'(m_pend));
    check_val("interrupt", int'(interrupt), (m_pend != 3'b000) ? 1 : 0);
    check_val("frame_cnt", int'(frame_cnt), m_fc);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst      = v.rst;
    enable   = v.enable;
    irq_en   = v.irq_en;
    irq_clr  = v.irq_clr;
    line_cmp = v.line_cmp;
    repeat (v.cycles) step();
    check_val($sformatf("vec%0d_x", idx), int'(x), v.ex);
    check_val($sformatf("vec%0d_y", idx), int'(y), v.ey);
    check_val($sformatf("vec%0d_pending", idx), int'(irq_pending), v.epend);
    check_val($sformatf("vec%0d_frame_cnt", idx), int'(frame_cnt), v.efc);
  endtask

  vec_t vecs[14];

  initial begin
    int fs_count, ls_count;

    // rst, en, irq_en, irq_clr, line_cmp, cycles -> x, y, pending, frame_cnt
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 4'd0, 2,   0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 3'b000, 4'd0, 5,   5, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 3'b010, 3'b000, 4'd0, 59,  0, 4, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 3'b000, 4'd0, 1,   1, 4, 2, 0};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 3'b010, 4'd0, 1,   2, 4, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 3'b000, 4'd0, 62,  0, 0, 0, 1};
    vecs[6]  = '{1'b0, 1'b0, 3'b000, 3'b000, 4'd0, 3,   0, 0, 0, 1};
    vecs[7]  = '{1'b0, 1'b1, 3'b100, 3'b000, 4'd2, 40,  8, 2, 0, 1};
    vecs[8]  = '{1'b0, 1'b1, 3'b100, 3'b000, 4'd2, 1,   9, 2, 4, 1};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 3'b000, 4'd2, 10,  3, 3, 4, 1};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 3'b100, 4'd2, 1,   4, 3, 0, 1};
    vecs[11] = '{1'b0, 1'b1, 3'b011, 3'b000, 4'd2, 129, 5, 3, 3, 2};
    vecs[12] = '{1'b1, 1'b1, 3'b011, 3'b000, 4'd2, 1,   0, 0, 0, 0};
    vecs[13] = '{1'b0, 1'b1, 3'b100, 3'b000, 4'd9, 256, 0, 0, 0, 2};

    #2;
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Set and clear of the hblank bit on the same edge: the set must win.
    irq_en  = 3'b001;
    irq_clr = 3'b000;
    repeat (8) step();
    check_val("pre_setclr_x", int'(x), 8);
    irq_clr = 3'b001;
    step();
    check_val("setclr_pending", int'(irq_pending), 1);
    step();
    check_val("clr_pending", int'(irq_pending), 0);
    irq_clr = 3'b000;

    // One full frame from reset: exactly one frame_start and one line_start per line.
    rst = 1'b1;
    irq_en = 3'b000;
    step();
    rst = 1'b0;
    fs_count = 0;
    ls_count = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      fs_count += int'(frame_start);
      ls_count += int'(line_start);
    end
    check_val("frame_start_count", fs_count, 1);
    check_val("line_start_count", ls_count, VT);
    check_val("frame_end_cnt", int'(frame_cnt), 1);

    // Randomized traffic with occasional disable, reset and line_cmp changes.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      enable   = ($urandom_range(0, 15) != 0);
      irq_en   = 3'($urandom_range(0, 7));
      irq_clr  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 63) == 0) line_cmp = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
